// File: rtl/umi_console_pkg.sv
// umi_console_pkg: shared constants for the UMI console bridge.
//   UMI_CMD_POSTED_WRITE : UMI opcode used for console traffic in both directions
//   UMI_PUTC_ADDR        : default host-side target for printed bytes
//   UMI_GETC_ADDR        : default device-side address that feeds the rx byte
package umi_console_pkg;

  localparam logic [4:0]  UMI_CMD_POSTED_WRITE = 5'h05;
  localparam logic [63:0] UMI_PUTC_ADDR        = 64'h0000_0000_0100_0000;
  localparam logic [63:0] UMI_GETC_ADDR        = 64'h0000_0000_0100_0008;

endpackage

// File: rtl/umi_console_fifo.sv
// umi_console_fifo: DEPTH x WIDTH synchronous FIFO for the tx byte stream.
//   clk, nreset     : clock, async active-low reset (pointers only)
//   push, din       : write request / data (ignored while full)
//   pop, dout       : read request (ignored while empty) / head of queue
//   full, empty     : status
//   count           : entries currently stored (0..DEPTH)
module umi_console_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr, rd_ptr;
  logic        wr_en, rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/umi_console.sv
// umi_console: byte console over UMI.
//   tx side  : tx_valid/tx_data/tx_ready push bytes into a DEPTH-entry FIFO;
//              tx_level reports FIFO occupancy (excludes the byte held in the
//              host request stage).
//   uhost_*  : registered UMI posted writes to PUTC_ADDR, one byte each in data[7:0].
//   udev_*   : incoming UMI requests; posted writes to GETC_ADDR load the rx byte,
//              anything else is accepted and dropped.
//   rx side  : rx_valid/rx_data/rx_ready single-entry received-byte register.
module umi_console
  import umi_console_pkg::*;
#(
  parameter int                    CMD_WIDTH  = 32,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 128,
  parameter int                    DEPTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] PUTC_ADDR  = ADDR_WIDTH'(UMI_PUTC_ADDR),
  parameter logic [ADDR_WIDTH-1:0] GETC_ADDR  = ADDR_WIDTH'(UMI_GETC_ADDR)
) (
  input  logic                    clk,
  input  logic                    nreset,
  // tx byte stream
  input  logic                    tx_valid,
  input  logic [7:0]              tx_data,
  output logic                    tx_ready,
  output logic [$clog2(DEPTH):0]  tx_level,
  // UMI host request
  output logic                    uhost_req_valid,
  output logic [CMD_WIDTH-1:0]    uhost_req_cmd,
  output logic [ADDR_WIDTH-1:0]   uhost_req_dstaddr,
  output logic [ADDR_WIDTH-1:0]   uhost_req_srcaddr,
  output logic [DATA_WIDTH-1:0]   uhost_req_data,
  input  logic                    uhost_req_ready,
  // UMI device request
  input  logic                    udev_req_valid,
  input  logic [CMD_WIDTH-1:0]    udev_req_cmd,
  input  logic [ADDR_WIDTH-1:0]   udev_req_dstaddr,
  input  logic [ADDR_WIDTH-1:0]   udev_req_srcaddr,
  input  logic [DATA_WIDTH-1:0]   udev_req_data,
  output logic                    udev_req_ready,
  // rx byte
  output logic                    rx_valid,
  output logic [7:0]              rx_data,
  input  logic                    rx_ready
);

  typedef struct packed {
    logic [CMD_WIDTH-1:0]  cmd;
    logic [ADDR_WIDTH-1:0] dstaddr;
    logic [ADDR_WIDTH-1:0] srcaddr;
    logic [DATA_WIDTH-1:0] data;
  } umi_req_t;

  // ---------------------------------------------------------------- tx FIFO
  logic       fifo_full, fifo_empty, load;
  logic [7:0] fifo_dout;

  assign tx_ready = !fifo_full;

  umi_console_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (tx_valid && tx_ready),
    .din    (tx_data),
    .pop    (load),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (tx_level)
  );

  // ------------------------------------------------------ host request stage
  // Refill whenever the stage is free or being drained this cycle, so a
  // continuously ready host sees one request per cycle. uhost_req_ready only
  // reaches registers, never uhost_req_valid directly.
  umi_req_t host_q, host_d;
  logic     host_vld;

  assign load = (!host_vld || uhost_req_ready) && !fifo_empty;

  always_comb begin
    host_d         = '0;
    host_d.cmd     = CMD_WIDTH'(UMI_CMD_POSTED_WRITE);
    host_d.dstaddr = PUTC_ADDR;
    host_d.data    = DATA_WIDTH'(fifo_dout);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      host_vld <= 1'b0;
      host_q   <= '0;
    end else if (load) begin
      host_vld <= 1'b1;
      host_q   <= host_d;
    end else if (uhost_req_ready) begin
      host_vld <= 1'b0;
    end
  end

  assign uhost_req_valid   = host_vld;
  assign uhost_req_cmd     = host_q.cmd;
  assign uhost_req_dstaddr = host_q.dstaddr;
  assign uhost_req_srcaddr = host_q.srcaddr;
  assign uhost_req_data    = host_q.data;

  // ------------------------------------------------------------- rx capture
  logic dev_acc, dev_hit;

  assign udev_req_ready = !rx_valid || rx_ready;
  assign dev_acc        = udev_req_valid && udev_req_ready;
  assign dev_hit        = dev_acc &&
                          (udev_req_cmd[4:0] == UMI_CMD_POSTED_WRITE) &&
                          (udev_req_dstaddr == GETC_ADDR);

  // A hit in the same cycle the consumer drains simply replaces the byte.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else if (dev_hit) begin
      rx_valid <= 1'b1;
      rx_data  <= udev_req_data[7:0];
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // Device request fields that carry no meaning for the console.
  logic unused_dev;
  assign unused_dev = ^{udev_req_srcaddr, udev_req_cmd[CMD_WIDTH-1:5],
                        udev_req_data[DATA_WIDTH-1:8]};

endmodule

// File: tb/tb_umi_console.sv
module tb_umi_console;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         nreset;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         tx_ready;
  logic [4:0]   tx_level;
  logic         uhost_req_valid;
  logic [31:0]  uhost_req_cmd;
  logic [63:0]  uhost_req_dstaddr;
  logic [63:0]  uhost_req_srcaddr;
  logic [127:0] uhost_req_data;
  logic         uhost_req_ready;
  logic         udev_req_valid;
  logic [31:0]  udev_req_cmd;
  logic [63:0]  udev_req_dstaddr;
  logic [63:0]  udev_req_srcaddr;
  logic [127:0] udev_req_data;
  logic         udev_req_ready;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         rx_ready;

  always #5 clk = ~clk;

  umi_console dut (
    .clk               (clk),
    .nreset            (nreset),
    .tx_valid          (tx_valid),
    .tx_data           (tx_data),
    .tx_ready          (tx_ready),
    .tx_level          (tx_level),
    .uhost_req_valid   (uhost_req_valid),
    .uhost_req_cmd     (uhost_req_cmd),
    .uhost_req_dstaddr (uhost_req_dstaddr),
    .uhost_req_srcaddr (uhost_req_srcaddr),
    .uhost_req_data    (uhost_req_data),
    .uhost_req_ready   (uhost_req_ready),
    .udev_req_valid    (udev_req_valid),
    .udev_req_cmd      (udev_req_cmd),
    .udev_req_dstaddr  (udev_req_dstaddr),
    .udev_req_srcaddr  (udev_req_srcaddr),
    .udev_req_data     (udev_req_data),
    .udev_req_ready    (udev_req_ready),
    .rx_valid          (rx_valid),
    .rx_data           (rx_data),
    .rx_ready          (rx_ready)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bytes accepted on tx but not yet seen on the host port.
  logic [7:0]   exp_q[$];
  int           taken  = 0;
  int           pushed = 0;
  logic         pend = 1'b0;
  logic [127:0] pend_data;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; observes the
  // transfers the coming rising edge will perform, then advances one cycle.
  task automatic tick();
    logic [7:0] e;
    #1;
    if (pend) begin
      chk("hold_valid", {127'b0, uhost_req_valid}, 128'd1);
      chk("hold_data", uhost_req_data, pend_data);
    end
    if (tx_valid && tx_ready) begin
      exp_q.push_back(tx_data);
      pushed++;
    end
    if (uhost_req_valid && uhost_req_ready) begin
      if (exp_q.size() == 0) begin
        chk("host_unexpected", {127'b0, uhost_req_valid}, 128'd0);
      end else begin
        e = exp_q.pop_front();
        chk("host_data", uhost_req_data, {120'b0, e});
        chk("host_cmd", {96'b0, uhost_req_cmd}, 128'h5);
        chk("host_dst", {64'b0, uhost_req_dstaddr}, 128'h100_0000);
        chk("host_src", {64'b0, uhost_req_srcaddr}, 128'h0);
        taken++;
      end
    end
    pend      = uhost_req_valid && !uhost_req_ready;
    pend_data = uhost_req_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int base;
    int n;

    nreset           = 1'b0;
    tx_valid         = 1'b0;
    tx_data          = '0;
    uhost_req_ready  = 1'b0;
    udev_req_valid   = 1'b0;
    udev_req_cmd     = '0;
    udev_req_dstaddr = '0;
    udev_req_srcaddr = '0;
    udev_req_data    = '0;
    rx_ready         = 1'b0;
    #1;
    chk("rst_valid", {127'b0, uhost_req_valid}, 128'd0);
    chk("rst_level", {123'b0, tx_level}, 128'd0);
    chk("rst_txready", {127'b0, tx_ready}, 128'd1);
    chk("rst_cmd", {96'b0, uhost_req_cmd}, 128'd0);
    chk("rst_dst", {64'b0, uhost_req_dstaddr}, 128'd0);
    chk("rst_data", uhost_req_data, 128'd0);
    chk("rst_rxvalid", {127'b0, rx_valid}, 128'd0);
    chk("rst_rxdata", {120'b0, rx_data}, 128'd0);
    chk("rst_udevready", {127'b0, udev_req_ready}, 128'd1);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // "Hi\n" with the host always ready: 2-cycle latency, then no bubbles.
    uhost_req_ready = 1'b1;
    tx_valid = 1'b1; tx_data = 8'h48; tick();
    chk("lat_valid_early", {127'b0, uhost_req_valid}, 128'd0);
    chk("lat_level", {123'b0, tx_level}, 128'd1);
    tx_data = 8'h69; tick();
    chk("hi_v0", {127'b0, uhost_req_valid}, 128'd1);
    chk("hi_d0", {120'b0, uhost_req_data[7:0]}, 128'h48);
    tx_data = 8'h0A; tick();
    chk("hi_v1", {127'b0, uhost_req_valid}, 128'd1);
    chk("hi_d1", {120'b0, uhost_req_data[7:0]}, 128'h69);
    tx_valid = 1'b0; tick();
    chk("hi_v2", {127'b0, uhost_req_valid}, 128'd1);
    chk("hi_d2", {120'b0, uhost_req_data[7:0]}, 128'h0A);
    tick();
    chk("hi_idle", {127'b0, uhost_req_valid}, 128'd0);
    chk("hi_taken", taken, 128'd3);

    // Fill with the host stalled. The first byte moves into the request
    // stage, so DEPTH more fit in the FIFO before tx_ready drops.
    uhost_req_ready = 1'b0;
    base = taken;
    for (int i = 0; i <= DEPTH; i++) begin
      tx_valid = 1'b1; tx_data = 8'(8'h10 + i);
      #1 chk("fill_ready", {127'b0, tx_ready}, 128'd1);
      tick();
    end
    chk("full_ready", {127'b0, tx_ready}, 128'd0);
    chk("full_level", {123'b0, tx_level}, 128'd16);
    tx_data = 8'hEE; tick();
    chk("full_refuse", {123'b0, tx_level}, 128'd16);
    tx_valid = 1'b0; uhost_req_ready = 1'b1;
    n = 0;
    while (taken - base < DEPTH + 1 && n < 100) begin tick(); n++; end
    chk("full_drained", taken - base, DEPTH + 1);
    chk("full_level_end", {123'b0, tx_level}, 128'd0);

    // 100 random bytes against a 50% random host ready.
    base = pushed;
    n = 0;
    while ((pushed - base < 100 || exp_q.size() != 0) && n < 3000) begin
      tx_valid        = (pushed - base < 100) && ($urandom_range(0, 1) == 1);
      tx_data         = 8'($urandom);
      uhost_req_ready = ($urandom_range(0, 1) == 1);
      tick();
      n++;
    end
    tx_valid = 1'b0; uhost_req_ready = 1'b1;
    tick(); tick();
    chk("rand_pushed", pushed - base, 100);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_idle", {127'b0, uhost_req_valid}, 128'd0);

    // rx: matching write with consumer stalled, then back-pressure.
    udev_req_valid = 1'b1; udev_req_cmd = 32'h5;
    udev_req_dstaddr = 64'h100_0008; udev_req_data = 128'h41;
    rx_ready = 1'b0;
    #1 chk("rx_ready0", {127'b0, udev_req_ready}, 128'd1);
    tick();
    chk("rx_valid1", {127'b0, rx_valid}, 128'd1);
    chk("rx_data1", {120'b0, rx_data}, 128'h41);
    chk("rx_stall", {127'b0, udev_req_ready}, 128'd0);
    udev_req_data = 128'h42; tick();
    chk("rx_hold", {120'b0, rx_data}, 128'h41);
    chk("rx_hold_v", {127'b0, rx_valid}, 128'd1);
    rx_ready = 1'b1;
    #1 chk("rx_ready_rel", {127'b0, udev_req_ready}, 128'd1);
    tick();
    chk("rx_replace_v", {127'b0, rx_valid}, 128'd1);
    chk("rx_replace_d", {120'b0, rx_data}, 128'h42);
    udev_req_valid = 1'b0; tick();
    chk("rx_drain", {127'b0, rx_valid}, 128'd0);

    // Non-matching requests are accepted and dropped.
    rx_ready = 1'b0;
    udev_req_valid = 1'b1; udev_req_dstaddr = 64'h200_0000; udev_req_data = 128'h55;
    #1 chk("rx_other_acc", {127'b0, udev_req_ready}, 128'd1);
    tick();
    chk("rx_other_v", {127'b0, rx_valid}, 128'd0);
    chk("rx_other_d", {120'b0, rx_data}, 128'h42);
    udev_req_dstaddr = 64'h100_0008; udev_req_cmd = 32'h4; tick();
    chk("rx_badcmd_v", {127'b0, rx_valid}, 128'd0);
    // Only the low opcode bits select the command.
    udev_req_cmd = 32'hABC05; udev_req_data = {120'hFFFF, 8'h77}; tick();
    chk("rx_opc_v", {127'b0, rx_valid}, 128'd1);
    chk("rx_opc_d", {120'b0, rx_data}, 128'h77);
    udev_req_valid = 1'b0; rx_ready = 1'b1; tick();
    chk("rx_end", {127'b0, rx_valid}, 128'd0);

    // Reset with 5 bytes buffered and a request pending.
    uhost_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1; tx_data = 8'(8'hA0 + i); tick();
    end
    tx_valid = 1'b0;
    chk("pre_rst_valid", {127'b0, uhost_req_valid}, 128'd1);
    chk("pre_rst_level", {123'b0, tx_level}, 128'd4);
    #2 nreset = 1'b0;
    #1;
    chk("mid_rst_valid", {127'b0, uhost_req_valid}, 128'd0);
    chk("mid_rst_level", {123'b0, tx_level}, 128'd0);
    chk("mid_rst_ready", {127'b0, tx_ready}, 128'd1);
    chk("mid_rst_data", uhost_req_data, 128'd0);
    exp_q.delete();
    pend = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    uhost_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_idle", {127'b0, uhost_req_valid}, 128'd0);
    end
    base = taken;
    tx_valid = 1'b1; tx_data = 8'h5A; tick();
    tx_valid = 1'b0; tick(); tick(); tick();
    chk("post_rst_one", taken - base, 1);
    chk("post_rst_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
